tri_raster_engine: RTL and testbench
====================================

// Module: tri_raster_engine
// PURPOSE
//  Parametrised successor of the right-angle triangle renderer: rasterises ANY triangle (any orientation,
//  any vertex order) on a 2^CW x 2^CW grid. Vertices arrive serially; covered pixels stream out row-major
//  with a valid/ready handshake to the pixel sink. Sits between vertex front-end and frame-buffer writer.
// PARAMETERS
//  CW       3   coordinate width in bits (1..8); grid is 0..2^CW-1 on both axes
//  EDGE_INC 1   1: pixels exactly on an edge are covered; 0: only strictly interior pixels
// PORTS
//  clk       in   1    clock, all state on rising edge
//  reset     in   1    asynchronous, active-low reset (0 = reset)
//  nt        in   1    new triangle strobe, qualifies vertex 0 on xi/yi; honoured only when busy=0
//  xi, yi    in   CW   vertex coordinates: V0 with nt, V1 next cycle, V2 the cycle after
//  out_ready in   1    pixel sink can accept xo/yo this cycle
//  busy      out  1    triangle in progress; further nt ignored
//  po        out  1    xo/yo valid (covered pixel)
//  xo, yo    out  CW   covered pixel coordinates
//  done      out  1    one-cycle pulse: triangle complete
// BEHAVIOUR
//  - Reset (async assert, sync release): busy=po=done=0, xo=yo=0, state IDLE, vertex regs 0.
//  - FSM: IDLE -nt-> LD1 -> LD2 -> SETUP -> SCAN -> FIN -> IDLE.
//    IDLE: latch V0. LD1: latch V1, busy<=1. LD2: latch V2. Vertex inputs sampled unconditionally in LD1/LD2.
//    SETUP (1 cycle): bbox xmin/xmax/ymin/ymax; A = signed 2x area = (x1-x0)(y2-y0)-(y1-y0)(x2-x0);
//      A==0 (degenerate) -> FIN directly, no pixel emitted.
//    SCAN: candidate (cx,cy) starts at (xmin,ymin); x increments to xmax, then x=xmin, y++; ends after (xmax,ymax).
//    FIN: busy<=0, done<=1 for one cycle, -> IDLE; nt is first honoured the cycle after FIN.
//  - Edge functions Ek = (xb-xa)(cy-ya)-(yb-ya)(cx-xa) for edges V0V1,V1V2,V2V0; signed, width 2*CW+2,
//    no truncation. Covered iff every Ek*sign(A) > 0, or >= 0 when EDGE_INC=1. Vertex order irrelevant.
//  - Throughput: one candidate per cycle. Uncovered candidate: po<=0, advance. Covered: po<=1, xo/yo<=cand.
//  - Handshake: transfer when po&&out_ready. While po&&!out_ready: po, xo, yo held stable, scan stalled.
//  - Latency: first candidate result on po 1 cycle after SCAN entry; done 1 cycle after last transfer/candidate.
//  - Pixels emitted strictly row-major (y outer ascending, x inner ascending), each covered pixel exactly once.
//  - Boundaries: bbox of width/height 1 legal; coordinates 0 and 2^CW-1 handled without wrap (counters CW+1 wide);
//    nt while busy ignored; reset mid-SCAN aborts immediately, no done pulse; out_ready ignored when po=0.
// CONFIGURATION
//  TRI_PIXCNT_EN defined: extra output pix_cnt [2*CW:0] = covered pixels transferred for the current triangle,
//    cleared in LD1, stable from done pulse until next LD1; reset 0.
//  TRI_PIXCNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package tri_raster_pkg: state_t enum {IDLE,LD1,LD2,SETUP,SCAN,FIN}; localparams for edge width
//    (2*CW+2) and counter width; function for bbox min/max of three values.
//  Sub-module tri_edge_eval (param CW): combinational; vertices + candidate in, three signed Ek and covered out.
//  Top keeps FSM, vertex/bbox regs, scan counters, output regs and handshake.
// TESTING
//  1. CW=3, V(0,0),(3,0),(0,3), ready=1 -> 10 pixels row-major (0,0)..(3,0),(0,1)..(2,1),(0,2),(1,2),(0,3); done once.
//  2. Same vertices listed in clockwise order (0,0),(0,3),(3,0) -> identical pixel stream.
//  3. Degenerate V(1,1),(3,3),(5,5) -> po never 1, done 4 cycles after nt (LD1,LD2,SETUP,FIN).
//  4. V(0,0),(7,0),(0,7), out_ready toggled randomly -> xo/yo stable while stalled; 36 pixels; no loss/dup.
//  5. Reset low mid-SCAN -> outputs 0 immediately, no done; next nt renders full triangle correctly.
//  6. EDGE_INC=0, V(0,0),(4,0),(0,4) -> only (1,1),(2,1),(1,2); with TRI_PIXCNT_EN pix_cnt=3 at done.

Source files
------------

// File: rtl/tri_raster_pkg.sv
// Shared types and helpers for the triangle rasteriser.
// Optional build macro TRI_PIXCNT_EN (used by tri_raster_engine) adds a transferred-pixel counter.
package tri_raster_pkg;

  typedef enum logic [2:0] {IDLE, LD1, LD2, SETUP, SCAN, FIN} state_t;

  localparam int MAX_CW = 8;
  typedef logic [MAX_CW:0] coord_t;

  // Widths derive from the instance's CW, so they are exposed as functions.
  function automatic int edge_w(input int cw);
    return 2 * cw + 2;
  endfunction

  function automatic int cnt_w(input int cw);
    return cw + 1;
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_edge_eval.sv
// Combinational edge-function evaluation of one candidate pixel against a triangle.
module tri_edge_eval
  import tri_raster_pkg::*;
#(
  parameter int CW       = 3,
  parameter int EDGE_INC = 1
) (
  input  logic [CW-1:0]          x0,
  input  logic [CW-1:0]          y0,
  input  logic [CW-1:0]          x1,
  input  logic [CW-1:0]          y1,
  input  logic [CW-1:0]          x2,
  input  logic [CW-1:0]          y2,
  input  logic [CW:0]            cx,
  input  logic [CW:0]            cy,
  input  logic                   a_neg,
  output logic signed [2*CW+1:0] e0,
  output logic signed [2*CW+1:0] e1,
  output logic signed [2*CW+1:0] e2,
  output logic                   covered
);

  localparam int EW = edge_w(CW);

  function automatic logic signed [EW-1:0] edge_fn(
    input logic [CW-1:0] xa, input logic [CW-1:0] ya,
    input logic [CW-1:0] xb, input logic [CW-1:0] yb,
    input logic [CW:0]   px, input logic [CW:0]   py
  );
    logic signed [EW-1:0] dxe, dye, dxp, dyp;
    dxe = EW'(xb) - EW'(xa);
    dye = EW'(yb) - EW'(ya);
    dxp = EW'(px) - EW'(xa);
    dyp = EW'(py) - EW'(ya);
    return dxe * dyp - dye * dxp;
  endfunction

  assign e0 = edge_fn(x0, y0, x1, y1, cx, cy);
  assign e1 = edge_fn(x1, y1, x2, y2, cx, cy);
  assign e2 = edge_fn(x2, y2, x0, y0, cx, cy);

  logic signed [EW-1:0] f0, f1, f2;

  // Folding sign(A) into the edge values makes the test winding-independent.
  always_comb begin
    f0 = a_neg ? -e0 : e0;
    f1 = a_neg ? -e1 : e1;
    f2 = a_neg ? -e2 : e2;
    if (EDGE_INC != 0)
      covered = !f0[EW-1] && !f1[EW-1] && !f2[EW-1];
    else
      covered = !f0[EW-1] && (f0 != '0) && !f1[EW-1] && (f1 != '0)
             && !f2[EW-1] && (f2 != '0);
  end

endmodule

// File: rtl/tri_raster_engine.sv
// Triangle rasteriser: serial vertex load, bbox scan, row-major pixel stream with valid/ready.
// Optional build macro TRI_PIXCNT_EN adds output pix_cnt (covered pixels transferred this triangle).
module tri_raster_engine
  import tri_raster_pkg::*;
#(
  parameter int CW       = 3,
  parameter int EDGE_INC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          nt,
  input  logic [CW-1:0] xi,
  input  logic [CW-1:0] yi,
  input  logic          out_ready,
  output logic          busy,
  output logic          po,
  output logic [CW-1:0] xo,
  output logic [CW-1:0] yo,
  output logic          done
`ifdef TRI_PIXCNT_EN
  ,
  output logic [2*CW:0] pix_cnt
`endif
);

  localparam int EW = edge_w(CW);
  localparam int NW = cnt_w(CW);

  state_t               state;
  logic [CW-1:0]        x0, y0, x1, y1, x2, y2;
  logic [NW-1:0]        xmin, xmax, ymax, cx, cy;
  logic                 a_neg, exh;
  logic signed [EW-1:0] e0, e1, e2, area;
  logic                 covered;
  logic                 stall;

  tri_edge_eval #(.CW(CW), .EDGE_INC(EDGE_INC)) u_edge (
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .cx(cx), .cy(cy), .a_neg(a_neg),
    .e0(e0), .e1(e1), .e2(e2), .covered(covered)
  );

  // The three edge functions sum to the doubled signed area at any point,
  // so SETUP reuses the evaluator instead of a separate area multiplier pair.
  assign area  = e0 + e1 + e2;
  assign stall = po && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
      xmin <= '0; xmax <= '0; ymax <= '0; cx <= '0; cy <= '0;
      a_neg <= 1'b0; exh <= 1'b0;
      busy <= 1'b0; po <= 1'b0; done <= 1'b0;
      xo <= '0; yo <= '0;
`ifdef TRI_PIXCNT_EN
      pix_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nt) begin
            x0    <= xi;
            y0    <= yi;
            state <= LD1;
          end
        end
        LD1: begin
          x1    <= xi;
          y1    <= yi;
          busy  <= 1'b1;
`ifdef TRI_PIXCNT_EN
          pix_cnt <= '0;
`endif
          state <= LD2;
        end
        LD2: begin
          x2    <= xi;
          y2    <= yi;
          state <= SETUP;
        end
        SETUP: begin
          xmin  <= NW'(min3(coord_t'(x0), coord_t'(x1), coord_t'(x2)));
          xmax  <= NW'(max3(coord_t'(x0), coord_t'(x1), coord_t'(x2)));
          ymax  <= NW'(max3(coord_t'(y0), coord_t'(y1), coord_t'(y2)));
          cx    <= NW'(min3(coord_t'(x0), coord_t'(x1), coord_t'(x2)));
          cy    <= NW'(min3(coord_t'(y0), coord_t'(y1), coord_t'(y2)));
          a_neg <= area[EW-1];
          exh   <= 1'b0;
          state <= (area == '0) ? FIN : SCAN;
        end
        SCAN: begin
          if (!stall) begin
`ifdef TRI_PIXCNT_EN
            if (po) pix_cnt <= pix_cnt + (2*CW+1)'(1);
`endif
            if (exh) begin
              po    <= 1'b0;
              state <= FIN;
            end else begin
              po <= covered;
              if (covered) begin
                xo <= cx[CW-1:0];
                yo <= cy[CW-1:0];
              end
              if (cx == xmax) begin
                cx <= xmin;
                if (cy == ymax) exh <= 1'b1;
                else            cy  <= cy + NW'(1);
              end else begin
                cx <= cx + NW'(1);
              end
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_engine.sv
// Directed bench for tri_raster_engine: inclusive-edge instance plus a strict-interior instance.
module tb_tri_raster_engine;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          nt = 1'b0;
  logic [CW-1:0] xi = '0;
  logic [CW-1:0] yi = '0;
  logic          out_ready = 1'b1;
  logic          busy1, po1, done1, busy2, po2, done2;
  logic [CW-1:0] xo1, yo1, xo2, yo2;
`ifdef TRI_PIXCNT_EN
  logic [2*CW:0] cnt1, cnt2;
`endif

  logic          sel = 1'b0;
  logic          o_busy, o_po, o_done;
  logic [CW-1:0] o_xo, o_yo;

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];
  int exp_q[$];

  always #5 clk = ~clk;

  tri_raster_engine #(.CW(CW), .EDGE_INC(1)) dut (
    .clk(clk), .reset(reset), .nt(nt), .xi(xi), .yi(yi), .out_ready(out_ready),
    .busy(busy1), .po(po1), .xo(xo1), .yo(yo1), .done(done1)
`ifdef TRI_PIXCNT_EN
    , .pix_cnt(cnt1)
`endif
  );

  tri_raster_engine #(.CW(CW), .EDGE_INC(0)) dut_strict (
    .clk(clk), .reset(reset), .nt(nt), .xi(xi), .yi(yi), .out_ready(out_ready),
    .busy(busy2), .po(po2), .xo(xo2), .yo(yo2), .done(done2)
`ifdef TRI_PIXCNT_EN
    , .pix_cnt(cnt2)
`endif
  );

  assign o_busy = sel ? busy2 : busy1;
  assign o_po   = sel ? po2   : po1;
  assign o_done = sel ? done2 : done1;
  assign o_xo   = sel ? xo2   : xo1;
  assign o_yo   = sel ? yo2   : yo1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Right triangle with legs n along both axes, inclusive edges: x + y <= n.
  task automatic build_right(input int n);
    exp_q.delete();
    for (int y = 0; y <= n; y++)
      for (int x = 0; x <= n - y; x++)
        exp_q.push_back(x * 8 + y);
  endtask

  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input string tag);
    @(negedge clk);
    nt = 1'b1; xi = CW'(ax); yi = CW'(ay);
    @(negedge clk);
    nt = 1'b0; xi = CW'(bx); yi = CW'(by);
    @(negedge clk);
    check({tag, "_busy_after_ld1"}, 32'(o_busy), 32'd1);
    xi = CW'(cx); yi = CW'(cy);
  endtask

  task automatic collect(input bit rnd, input bit poke, input string tag);
    bit            stalled = 1'b0;
    bit            fin = 1'b0;
    logic [CW-1:0] hx = '0;
    logic [CW-1:0] hy = '0;
    int            n;
    got.delete();
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      nt = poke && (c == 5);
      xi = nt ? CW'(5) : '0;
      yi = nt ? CW'(6) : '0;
      if (stalled) begin
        check({tag, "_hold_po"}, 32'(o_po), 32'd1);
        check({tag, "_hold_xy"}, 32'({o_xo, o_yo}), 32'({hx, hy}));
      end
      if (o_done) begin
        fin = 1'b1;
        check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
`ifdef TRI_PIXCNT_EN
        check({tag, "_pix_cnt"}, 32'(sel ? cnt2 : cnt1), 32'(exp_q.size()));
`endif
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (o_po && out_ready) got.push_back(int'({o_xo, o_yo}));
        stalled = o_po && !out_ready;
        hx = o_xo;
        hy = o_yo;
      end
    end
    nt = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(fin), 32'd1);
    check({tag, "_pixel_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pixel%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_po", 32'(po1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_xy", 32'({xo1, yo1}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: counter-clockwise right triangle
    build_right(3);
    send(0, 0, 3, 0, 0, 3, "t1");
    collect(1'b0, 1'b0, "t1");

    // 2: same triangle, clockwise vertex order
    send(0, 0, 0, 3, 3, 0, "t2");
    collect(1'b0, 1'b0, "t2");

    // 3: degenerate (collinear) triangle
    send(1, 1, 3, 3, 5, 5, "t3");
    @(negedge clk);
    check("t3_done_setup", 32'(done1), 32'd0);
    @(negedge clk);
    check("t3_done_fin", 32'(done1), 32'd0);
    check("t3_po_fin", 32'(po1), 32'd0);
    @(negedge clk);
    check("t3_done_pulse", 32'(done1), 32'd1);
    check("t3_busy_clear", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);

    // 4: full-grid triangle, random backpressure, stray nt while busy
    build_right(7);
    send(0, 0, 7, 0, 0, 7, "t4");
    collect(1'b1, 1'b1, "t4");

    // 5: reset mid-scan, then a clean render
    send(0, 0, 3, 0, 0, 3, "t5");
    seen = 0;
    for (int c = 0; c < 30 && seen < 2; c++) begin
      @(negedge clk);
      if (po1) seen++;
    end
    check("t5_scan_started", 32'(seen), 32'd2);
    reset = 1'b0;
    #1;
    check("t5_rst_po", 32'(po1), 32'd0);
    check("t5_rst_busy", 32'(busy1), 32'd0);
    check("t5_rst_xy", 32'({xo1, yo1}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t5_no_done", 32'(done1), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("t5_idle_done", 32'(done1), 32'd0);
    build_right(3);
    send(0, 0, 3, 0, 0, 3, "t5b");
    collect(1'b0, 1'b0, "t5b");

    // 6: strict interior only, observed on the EDGE_INC=0 instance
    sel = 1'b1;
    exp_q.delete();
    exp_q.push_back(1 * 8 + 1);
    exp_q.push_back(2 * 8 + 1);
    exp_q.push_back(1 * 8 + 2);
    send(0, 0, 4, 0, 0, 4, "t6");
    collect(1'b0, 1'b0, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
